// File: rtl/tribus_arbiter.sv
// Round-robin owner arbiter for a shared tri-state bus: one-hot buffer enables,
// bounded tenure and an all-high-Z turnaround gap between owners.
module tribus_arbiter #(
    parameter int unsigned NREQ     = 4,
    parameter int unsigned MAXBURST = 8,
    parameter int unsigned TURN     = 1,
    localparam int unsigned IDW     = $clog2(NREQ),
    localparam int unsigned MBW     = $clog2(MAXBURST + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] en,
    output logic [IDW-1:0]  gnt_id,
    output logic            bus_own,
    output logic [MBW-1:0]  beat
);

    localparam int unsigned GCW = $clog2(TURN + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t           state, state_d;
    logic [IDW-1:0]   ptr, ptr_d;
    logic [GCW-1:0]   gap_cnt, gap_d;
    logic [NREQ-1:0]  en_d;
    logic [IDW-1:0]   gnt_d;
    logic             bus_d;
    logic [MBW-1:0]   beat_d;

    logic             win_any;
    logic [IDW-1:0]   win_id;

    // Rotating-priority search: first requester strictly after ptr, wrapping.
    always_comb begin
        int unsigned idx;
        win_any = 1'b0;
        win_id  = '0;
        idx     = 0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = 32'(ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!win_any && req[IDW'(idx)]) begin
                win_any = 1'b1;
                win_id  = IDW'(idx);
            end
        end
    end

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_d = state;
        ptr_d   = ptr;
        gap_d   = gap_cnt;
        en_d    = en;
        gnt_d   = gnt_id;
        bus_d   = bus_own;
        beat_d  = beat;

        case (state)
            IDLE: begin
                if (win_any) begin
                    state_d = OWN;
                    en_d    = NREQ'(1) << win_id;
                    gnt_d   = win_id;
                    ptr_d   = win_id;
                    bus_d   = 1'b1;
                    beat_d  = MBW'(1);
                end else begin
                    en_d  = '0;
                    bus_d = 1'b0;
                end
            end

            OWN: begin
                // Owner keeps the bus only while requesting and under the burst cap.
                if (req[gnt_id] && (beat < MBW'(MAXBURST))) begin
                    beat_d = beat + MBW'(1);
                end else begin
                    state_d = GAP;
                    en_d    = '0;
                    bus_d   = 1'b0;
                    beat_d  = '0;
                    gap_d   = GCW'(TURN);
                end
            end

            GAP: begin
                // Last turnaround cycle doubles as the arbitration slot.
                if (gap_cnt <= GCW'(1)) begin
                    if (win_any) begin
                        state_d = OWN;
                        en_d    = NREQ'(1) << win_id;
                        gnt_d   = win_id;
                        ptr_d   = win_id;
                        bus_d   = 1'b1;
                        beat_d  = MBW'(1);
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    gap_d = gap_cnt - GCW'(1);
                end
            end

            default: begin
                state_d = IDLE;
                en_d    = '0;
                bus_d   = 1'b0;
                beat_d  = '0;
            end
        endcase
    end

    // State and output registers; reset parks ptr so index 0 wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ptr     <= IDW'(NREQ - 1);
            gap_cnt <= '0;
            en      <= '0;
            gnt_id  <= '0;
            bus_own <= 1'b0;
            beat    <= '0;
        end else begin
            state   <= state_d;
            ptr     <= ptr_d;
            gap_cnt <= gap_d;
            en      <= en_d;
            gnt_id  <= gnt_d;
            bus_own <= bus_d;
            beat    <= beat_d;
        end
    end

endmodule

// File: tb/tb_tribus_arbiter.sv
// Directed bench for tribus_arbiter (NREQ=4, MAXBURST=8, TURN=1).
module tb_tribus_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] en;
    logic [1:0] gnt_id;
    logic       bus_own;
    logic [3:0] beat;

    int n_cmp;
    int n_fail;

    tribus_arbiter #(
        .NREQ     (4),
        .MAXBURST (8),
        .TURN     (1)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .en      (en),
        .gnt_id  (gnt_id),
        .bus_own (bus_own),
        .beat    (beat)
    );

    // 10-unit clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [3:0] e_en, input logic [1:0] e_gnt,
                             input logic e_bus, input logic [3:0] e_beat);
        check({tag, ".en"},      32'(en),      32'(e_en));
        check({tag, ".gnt_id"},  32'(gnt_id),  32'(e_gnt));
        check({tag, ".bus_own"}, 32'(bus_own), 32'(e_bus));
        check({tag, ".beat"},    32'(beat),    32'(e_beat));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 4'b0000;
        tick();
        check_out("rst", 4'b0000, 2'd0, 1'b0, 4'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] prev_en;
        int         edges;
        n_cmp  = 0;
        n_fail = 0;
        clk    = 1'b0;
        rst_n  = 1'b0;
        req    = 4'b1111;

        // Reset held with all requests high
        repeat (3) tick();
        check_out("reset_hold", 4'b0000, 2'd0, 1'b0, 4'd0);
        rst_n = 1'b1;
        req   = 4'b0000;
        tick();
        check_out("idle0", 4'b0000, 2'd0, 1'b0, 4'd0);

        // Single requester, dropped after three beats
        req = 4'b0001;
        for (int b = 1; b <= 3; b++) begin
            tick();
            check_out($sformatf("single.b%0d", b), 4'b0001, 2'd0, 1'b1, 4'(b));
        end
        req = 4'b0000;
        tick();
        check_out("single.gap", 4'b0000, 2'd0, 1'b0, 4'd0);
        tick();
        check_out("single.idle", 4'b0000, 2'd0, 1'b0, 4'd0);
        tick();
        check_out("single.idle2", 4'b0000, 2'd0, 1'b0, 4'd0);

        // Round robin, all requesting: owners 0,1,2,3,0
        do_reset();
        req = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            for (int b = 1; b <= 8; b++) begin
                tick();
                check_out($sformatf("rr%0d.b%0d", t, b), 4'(1 << (t % 4)), 2'(t % 4), 1'b1, 4'(b));
            end
            if (t == 4) req = 4'b0000;
            tick();
            check_out($sformatf("rr%0d.gap", t), 4'b0000, 2'(t % 4), 1'b0, 4'd0);
        end
        tick();
        check_out("rr.idle", 4'b0000, 2'd0, 1'b0, 4'd0);

        // Burst limit: only req[2], 20 sampled cycles
        req = 4'b0100;
        for (int e = 1; e <= 20; e++) begin
            tick();
            if (e == 9 || e == 18)
                check_out($sformatf("burst.e%0d", e), 4'b0000, 2'd2, 1'b0, 4'd0);
            else if (e <= 8)
                check_out($sformatf("burst.e%0d", e), 4'b0100, 2'd2, 1'b1, 4'(e));
            else if (e <= 17)
                check_out($sformatf("burst.e%0d", e), 4'b0100, 2'd2, 1'b1, 4'(e - 9));
            else
                check_out($sformatf("burst.e%0d", e), 4'b0100, 2'd2, 1'b1, 4'(e - 18));
        end
        req = 4'b0000;
        tick();
        check_out("burst.gap", 4'b0000, 2'd2, 1'b0, 4'd0);
        tick();
        check_out("burst.idle", 4'b0000, 2'd2, 1'b0, 4'd0);

        // Asynchronous reset in the middle of a tenure
        do_reset();
        req = 4'b0010;
        tick();
        check_out("async.own1", 4'b0010, 2'd1, 1'b1, 4'd1);
        tick();
        check_out("async.own2", 4'b0010, 2'd1, 1'b1, 4'd2);
        #3;
        rst_n = 1'b0;
        #1;
        check_out("async.drop", 4'b0000, 2'd0, 1'b0, 4'd0);
        tick();
        rst_n = 1'b1;
        edges = 0;
        while (en == 4'b0000 && edges < 2) begin
            tick();
            edges++;
        end
        check("async.granted", 32'(en != 4'b0000), 32'd1);
        check_out("async.regrant", 4'b0010, 2'd1, 1'b1, 4'd1);

        // Random requests: never two enables, never a direct owner-to-owner handoff
        prev_en = en;
        for (int c = 0; c < 400; c++) begin
            req = 4'($urandom_range(0, 15));
            tick();
            check("rand.onehot", 32'($countones(en) <= 1), 32'd1);
            check("rand.busown", 32'(bus_own), 32'(en != 4'b0000));
            if (en != 4'b0000 && prev_en != 4'b0000)
                check("rand.handoff", 32'(en), 32'(prev_en));
            prev_en = en;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
